// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, parity types and line levels.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_state_e;
`endif

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Request/line bundle between a frame producer (master) and the UART transmitter (slave).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Captures the parity enable and the parity bit of the payload at the accepting edge,
// so later changes on the inputs cannot disturb the frame in flight.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  output logic                  par_en_o,
  output logic                  par_bit_o
);

  logic par_en_q;
  logic par_bit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept_i) begin
      par_en_q  <= par_en_i;
      par_bit_q <= (^data_i) ^ (par_typ_i == PAR_ODD);
    end
  end

  assign par_en_o  = par_en_q;
  assign par_bit_o = par_bit_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  accept;

  // Busy is low only in IDLE and STOP, which is exactly where a new frame may start.
  assign accept = bus.DATA_VALID && !busy_q;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk       (CLK),
    .rst_n     (RST),
    .accept_i  (accept),
    .data_i    (bus.P_DATA),
    .par_en_i  (bus.PAR_EN),
    .par_typ_i (bus.PAR_TYP),
    .par_en_o  (par_en_q),
    .par_bit_o (par_bit_q)
  );
`else
  logic unused_par;
  assign unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_STOP: begin
          if (accept) begin
            state_q <= ST_START;
            shift_q <= bus.P_DATA;
            cnt_q   <= '0;
            tx_q    <= START_LEVEL;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= '0;
        end
        ST_DATA: begin
          // cnt_q indexes the bit currently on the line.
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= STOP_LEVEL;
              busy_q  <= 1'b0;
            end
`else
            state_q <= ST_STOP;
            tx_q    <= STOP_LEVEL;
            busy_q  <= 1'b0;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state_q <= ST_STOP;
          tx_q    <= STOP_LEVEL;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line and Busy traces are packed one bit per cycle
// (bit i = cycle i, cycle 0 = start bit) and compared against hand-computed words.
module tb_uart_tx;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] txw;
  logic [31:0] bw;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int i);
    txw[i] = bus.TX_OUT;
    bw[i]  = bus.Busy;
  endtask

  // Presents a request for exactly one edge; afterwards cycle 0 (start bit) is on the line.
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic capture(input int n);
    txw = '0;
    bw  = '0;
    for (int i = 0; i < n; i++) begin
      sample(i);
      step();
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b0;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b1;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    step();
    step();
    check("rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    bus.DATA_VALID = 1'b0;
    rst = 1'b1;
    step();

    // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1 then idle
    launch(8'hA5, 1'b0, 1'b0);
    capture(12);
    check("a5_tx", txw, 32'hF4A);
    check("a5_busy", bw, 32'h1FF);

`ifdef UART_TX_PARITY_EN
    launch(8'hA5, 1'b1, 1'b0);
    capture(12);
    check("a5_even_tx", txw, 32'hD4A);
    check("a5_even_busy", bw, 32'h3FF);
    launch(8'hA5, 1'b1, 1'b1);
    capture(12);
    check("a5_odd_tx", txw, 32'hF4A);
    check("a5_odd_busy", bw, 32'h3FF);
`else
    launch(8'hA5, 1'b1, 1'b0);
    capture(12);
    check("a5_even_tx", txw, 32'hF4A);
    check("a5_even_busy", bw, 32'h1FF);
    launch(8'hA5, 1'b1, 1'b1);
    capture(12);
    check("a5_odd_tx", txw, 32'hF4A);
    check("a5_odd_busy", bw, 32'h1FF);
`endif

    // Back-to-back 0x00 then 0xFF, second request in the first frame's stop cycle
    launch(8'h00, 1'b0, 1'b0);
    txw = '0;
    bw  = '0;
    for (int i = 0; i < 22; i++) begin
      sample(i);
      if (i == 9) begin
        bus.P_DATA     = 8'hFF;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 10) bus.DATA_VALID = 1'b0;
      step();
    end
    check("b2b_tx", txw, 32'h3FFA00);
    check("b2b_busy", bw, 32'h7FDFF);

    // Reset while data bit 3 of 0x5A is on the line
    launch(8'h5A, 1'b0, 1'b0);
    capture(4);
    check("mid_pre", txw, 32'h4);
    check("mid_b3", {31'd0, bus.TX_OUT}, 32'd1);
    rst = 1'b0;
    step();
    check("mid_rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
    // Request on the first edge with reset released
    rst = 1'b1;
    launch(8'h5A, 1'b0, 1'b0);
    capture(11);
    check("5a_tx", txw, 32'h6B4);
    check("5a_busy", bw, 32'h1FF);

    // Request while busy is dropped, mid-frame input changes have no effect
    launch(8'hA5, 1'b0, 1'b0);
    txw = '0;
    bw  = '0;
    for (int i = 0; i < 14; i++) begin
      sample(i);
      if (i == 3) begin
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 8) bus.DATA_VALID = 1'b0;
      step();
    end
    check("ign_tx", txw, 32'h3F4A);
    check("ign_busy", bw, 32'h1FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the number of payload bits per frame.
REQ-002 Port CLK, input, 1, the single clock; every flop is clocked on its rising edge.
REQ-003 Port RST, input, 1, reset; synchronous and active-low.
REQ-004 Port P_DATA, input, DATA_WIDTH, parallel payload, sampled only at acceptance.
REQ-005 Port DATA_VALID, input, 1, request to send P_DATA.
REQ-006 Port PAR_EN, input, 1, parity bit enable, sampled at acceptance.
REQ-007 Port PAR_TYP, input, 1, parity type (0 = even, 1 = odd), sampled at acceptance.
REQ-008 Port TX_OUT, output, 1, registered serial line; idles high.
REQ-009 Port Busy, output, 1, registered; high while a frame cannot accept new data.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-011 Acceptance SHALL occur at a rising edge where DATA_VALID=1 and Busy=0; P_DATA, PAR_EN and PAR_TYP are latched at that edge.
REQ-012 After the accepting edge, the next cycle SHALL drive TX_OUT=0 (START), with zero idle latency.
REQ-013 DATA SHALL shift DATA_WIDTH bits, LSB first, one bit per CLK cycle, driven by a bit counter that wraps to 0 after bit DATA_WIDTH-1.
REQ-014 PARITY SHALL occur only when the latched PAR_EN=1 and SHALL drive the XOR of the latched data, inverted when PAR_TYP=1.
REQ-015 STOP SHALL drive TX_OUT=1 for exactly one cycle.
REQ-016 Frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-017 Busy SHALL be 1 during START, DATA and PARITY, and 0 during IDLE and STOP.
REQ-018 Acceptance during the STOP cycle SHALL go directly to START, giving back-to-back frames with no idle cycle.
REQ-019 Without acceptance, STOP SHALL go to IDLE.
REQ-020 While Busy=1, DATA_VALID SHALL be ignored and not queued.
REQ-021 Changes on P_DATA, PAR_EN or PAR_TYP mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-022 A rising edge with RST=0 SHALL force IDLE, TX_OUT=1, Busy=0, and clear the shift register, bit counter and parity flop.
REQ-023 Reset mid-frame SHALL abort the frame, and TX_OUT SHALL be 1 from the next cycle.
REQ-024 DATA_VALID on the first edge with RST=1 SHALL be accepted normally.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: parity SHALL behave per REQ-014.
REQ-026 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, PAR_EN and PAR_TYP SHALL remain as ports but be ignored, and every frame SHALL be DATA_WIDTH+2 cycles.

Structure
REQ-027 The shared package uart_pkg SHALL hold:
- FSM state encoding
- PAR_EVEN/PAR_ODD constants
- IDLE_LEVEL/START_LEVEL/STOP_LEVEL line constants
REQ-028 Parity computation SHALL be sub-module uart_tx_parity_calc, which latches the parity bit at acceptance.
REQ-029 The FSM, serializer and output mux SHALL remain in uart_tx.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, then idle 1; Busy high for 9 cycles.
REQ-031 P_DATA=0xA5, PAR_EN=1:
- PAR_TYP=0 -> parity bit 0.
- PAR_TYP=1 -> parity bit 1.
- Both cases -> 11-cycle frame.
REQ-032 0x00 then 0xFF, second DATA_VALID asserted in the STOP cycle -> 20 contiguous bit cycles, no idle gap, second frame start bit immediately after the first frame's stop bit.
REQ-033 RST=0 during data bit 3 of 0x5A -> TX_OUT=1 and Busy=0 next cycle; a following 0x5A frame is bit-exact.
REQ-034 DATA_VALID with 0x3C while Busy=1 -> ignored; only the original frame is sent, and TX_OUT stays idle afterwards.
REQ-035 UART_TX_PARITY_EN undefined, PAR_EN=1, 0xA5 -> 10-cycle frame identical to REQ-030.
